// File: rtl/axi_slave_rd.sv
// axi_slave_rd: AXI read-side slave serving bursts from a local word-addressed memory.
// The memory is filled through a sideband write port, which is shared with the write slave.
// Optional feature macro: AXI_RD_WRAP_EN enables WRAP bursts (lengths 2, 4, 8 or 16 beats).
// Without AXI_RD_WRAP_EN, WRAP is treated as reserved and every beat returns SLVERR.
module axi_slave_rd #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 8,
    parameter int SIZE_BITS = 3,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                         aclk,
    input  logic                         areset_n,
    output logic                         ar_ready,
    input  logic                         ar_valid,
    input  logic [ADDR_BITS-1:0]         ar_addr,
    input  logic [LEN_BITS-1:0]          ar_len,
    input  logic [SIZE_BITS-1:0]         ar_size,
    input  logic [1:0]                   ar_burst,
    output logic                         r_valid,
    input  logic                         r_ready,
    output logic [DATA_BITS-1:0]         r_data,
    output logic                         r_last,
    output logic [1:0]                   r_resp,
    input  logic                         mem_wr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_wr_addr,
    input  logic [DATA_BITS-1:0]         mem_wr_data
);

    localparam int BPB      = DATA_BITS / 8;
    localparam int ADDR_LSB = $clog2(BPB);
    localparam int MW       = $clog2(MEM_DEPTH);
    localparam logic [ADDR_BITS-1:0] DEPTH_W  = ADDR_BITS'(MEM_DEPTH);
    localparam logic [SIZE_BITS-1:0] MAX_SIZE = SIZE_BITS'(ADDR_LSB);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t                 state_q;
    logic                   arReady_q;
    logic                   rValid_q;
    logic                   rLast_q;
    logic [1:0]             rResp_q;
    logic [DATA_BITS-1:0]   rData_q;
    logic [ADDR_BITS-1:0]   idx_q;
    logic [LEN_BITS-1:0]    beatCnt_q;
    logic [LEN_BITS-1:0]    len_q;
    logic [1:0]             burst_q;
    logic                   burstErr_q;

    logic [DATA_BITS-1:0]   mem [MEM_DEPTH];

    logic [ADDR_BITS-1:0]   arIdx_d;
    logic                   arBurstErr_d;
    logic [ADDR_BITS-1:0]   stepIdx_d;
    logic [ADDR_BITS-1:0]   loadIdx_d;
    logic                   loadErr_d;
    logic [DATA_BITS-1:0]   loadData_d;
    logic                   handshake_d;

`ifdef AXI_RD_WRAP_EN
    logic                   wrapLenOk_d;
    logic [ADDR_BITS-1:0]   wrapMask_d;
`endif

    // Classify the incoming request: errors that hold for every beat of the burst
    always_comb begin
        arIdx_d = ar_addr >> ADDR_LSB;
`ifdef AXI_RD_WRAP_EN
        wrapLenOk_d = (ar_len == LEN_BITS'(1)) || (ar_len == LEN_BITS'(3)) ||
                      (ar_len == LEN_BITS'(7)) || (ar_len == LEN_BITS'(15));
        arBurstErr_d = (ar_size > MAX_SIZE) || (ar_burst == 2'b11) ||
                       ((ar_burst == 2'b10) && !wrapLenOk_d);
`else
        arBurstErr_d = (ar_size > MAX_SIZE) || ar_burst[1];
`endif
    end

    // Next word index for the following beat of the active burst
    always_comb begin
        stepIdx_d = idx_q + ADDR_BITS'(1);
`ifdef AXI_RD_WRAP_EN
        wrapMask_d = ADDR_BITS'(len_q);
`endif
        case (burst_q)
            2'b00: stepIdx_d = idx_q;
            2'b01: stepIdx_d = idx_q + ADDR_BITS'(1);
`ifdef AXI_RD_WRAP_EN
            2'b10: stepIdx_d = (idx_q & ~wrapMask_d) | ((idx_q + ADDR_BITS'(1)) & wrapMask_d);
`endif
            default: stepIdx_d = idx_q + ADDR_BITS'(1);
        endcase
    end

    // Select the beat to load (first beat at handshake, next beat on acceptance) and read memory
    always_comb begin
        handshake_d = (state_q == IDLE) && ar_valid;
        loadIdx_d   = handshake_d ? arIdx_d : stepIdx_d;
        loadErr_d   = (handshake_d ? arBurstErr_d : burstErr_q) || (loadIdx_d >= DEPTH_W);
        loadData_d  = loadErr_d ? '0 : mem[loadIdx_d[MW-1:0]];
    end

    // Sideband memory fill; reads see the pre-write contents at the same edge
    always_ff @(posedge aclk) begin
        if (mem_wr_en) begin
            mem[mem_wr_addr] <= mem_wr_data;
        end
    end

    // Read FSM with registered AR/R channel outputs
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q    <= IDLE;
            arReady_q  <= 1'b1;
            rValid_q   <= 1'b0;
            rLast_q    <= 1'b0;
            rResp_q    <= RESP_OKAY;
            rData_q    <= '0;
            idx_q      <= '0;
            beatCnt_q  <= '0;
            len_q      <= '0;
            burst_q    <= 2'b00;
            burstErr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ar_valid) begin
                        len_q      <= ar_len;
                        burst_q    <= ar_burst;
                        burstErr_q <= arBurstErr_d;
                        idx_q      <= loadIdx_d;
                        beatCnt_q  <= '0;
                        rData_q    <= loadData_d;
                        rResp_q    <= loadErr_d ? RESP_SLVERR : RESP_OKAY;
                        rLast_q    <= (ar_len == '0);
                        rValid_q   <= 1'b1;
                        arReady_q  <= 1'b0;
                        state_q    <= BURST;
                    end
                end
                BURST: begin
                    if (r_ready) begin
                        if (rLast_q) begin
                            rValid_q  <= 1'b0;
                            rLast_q   <= 1'b0;
                            arReady_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            idx_q     <= loadIdx_d;
                            beatCnt_q <= beatCnt_q + LEN_BITS'(1);
                            rData_q   <= loadData_d;
                            rResp_q   <= loadErr_d ? RESP_SLVERR : RESP_OKAY;
                            rLast_q   <= ((beatCnt_q + LEN_BITS'(1)) == len_q);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ar_ready = arReady_q;
    assign r_valid  = rValid_q;
    assign r_last   = rLast_q;
    assign r_resp   = rResp_q;
    assign r_data   = rData_q;

endmodule

// File: tb/tb_axi_slave_rd.sv
// tb_axi_slave_rd: table-driven directed bursts, reset/collision sequences and
// randomized bursts checked against a behavioural model of the read slave.
module tb_axi_slave_rd;

    logic        aclk;
    logic        areset_n;
    logic        ar_ready;
    logic        ar_valid;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_data;
    logic        r_last;
    logic [1:0]  r_resp;
    logic        mem_wr_en;
    logic [9:0]  mem_wr_addr;
    logic [31:0] mem_wr_data;

    int errors = 0;
    int checks = 0;

    logic [31:0] refMem  [1024];
    logic [31:0] expData [256];
    logic [1:0]  expResp [256];

    typedef struct {
        logic [31:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        int                mode;
        logic [3:0][31:0]  data;
        logic [3:0][1:0]   resp;
    } vec_t;

    vec_t vecs[$];

    axi_slave_rd dut (
        .aclk        (aclk),
        .areset_n    (areset_n),
        .ar_ready    (ar_ready),
        .ar_valid    (ar_valid),
        .ar_addr     (ar_addr),
        .ar_len      (ar_len),
        .ar_size     (ar_size),
        .ar_burst    (ar_burst),
        .r_valid     (r_valid),
        .r_ready     (r_ready),
        .r_data      (r_data),
        .r_last      (r_last),
        .r_resp      (r_resp),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkVec(input logic [31:0] addr, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst, input int mode,
                                   input logic [31:0] d0, input logic [31:0] d1,
                                   input logic [31:0] d2, input logic [31:0] d3,
                                   input logic [7:0] respPk);
        vec_t v;
        v.addr  = addr;
        v.len   = len;
        v.size  = size;
        v.burst = burst;
        v.mode  = mode;
        v.data  = {d3, d2, d1, d0};
        v.resp  = respPk;
        return v;
    endfunction

    task automatic writeMem(input int a, input logic [31:0] d);
        mem_wr_en   = 1'b1;
        mem_wr_addr = 10'(a);
        mem_wr_data = d;
        @(posedge aclk); #1;
        mem_wr_en   = 1'b0;
        refMem[a]   = d;
    endtask

    // Behavioural model: beat addresses and errors straight from the burst rules
    task automatic modelBurst(input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        longint idx0, idx, base, n;
        bit bad;
        idx0 = longint'(addr) / 4;
        n    = longint'(len) + 1;
        bad  = (size > 3'd2) || (burst == 2'b11);
`ifdef AXI_RD_WRAP_EN
        if (burst == 2'b10 && !(n == 2 || n == 4 || n == 8 || n == 16)) bad = 1'b1;
`else
        if (burst == 2'b10) bad = 1'b1;
`endif
        for (int i = 0; i < n; i++) begin
            case (burst)
                2'b00:   idx = idx0;
                2'b10: begin
                    base = (idx0 / n) * n;
                    idx  = base + ((idx0 - base + i) % n);
                end
                default: idx = idx0 + i;
            endcase
            if (bad || idx >= 1024) begin
                expData[i] = 32'h0;
                expResp[i] = 2'b10;
            end else begin
                expData[i] = refMem[int'(idx)];
                expResp[i] = 2'b00;
            end
        end
    endtask

    // Drives one AR request and walks every R beat against expData/expResp
    task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [7:0] len,
                                 input logic [2:0] size, input logic [1:0] burst, input int mode,
                                 input bit coll, input int collAddr, input logic [31:0] collData);
        int beat;
        int cyc;
        logic rdy;
        checkOutput({tag, " ar_ready idle"}, 64'(ar_ready), 64'd1);
        ar_valid = 1'b1;
        ar_addr  = addr;
        ar_len   = len;
        ar_size  = size;
        ar_burst = burst;
        if (coll) begin
            mem_wr_en   = 1'b1;
            mem_wr_addr = 10'(collAddr);
            mem_wr_data = collData;
        end
        @(posedge aclk); #1;
        ar_valid  = 1'b0;
        mem_wr_en = 1'b0;
        if (coll) refMem[collAddr] = collData;
        beat = 0;
        cyc  = 0;
        while (beat <= int'(len) && cyc < 400) begin
            checkOutput($sformatf("%s beat%0d", tag, beat),
                        64'({ar_ready, r_valid, r_last, r_resp, r_data}),
                        64'({1'b0, 1'b1, (beat == int'(len)), expResp[beat], expData[beat]}));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 3) == 0);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            r_ready = rdy;
            @(posedge aclk); #1;
            cyc++;
            if (rdy) beat++;
        end
        r_ready = 1'b0;
        if (cyc >= 400) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: got %0d beats expected %0d", tag, beat, int'(len) + 1);
        end
        checkOutput({tag, " end"}, 64'({ar_ready, r_valid, r_last}), 64'(3'b100));
    endtask

    task automatic runVec(input int i);
        for (int j = 0; j <= int'(vecs[i].len); j++) begin
            expData[j] = vecs[i].data[j];
            expResp[j] = vecs[i].resp[j];
        end
        applyStimulus($sformatf("vec%0d", i), vecs[i].addr, vecs[i].len, vecs[i].size,
                      vecs[i].burst, vecs[i].mode, 1'b0, 0, 32'h0);
    endtask

    initial begin
        logic [31:0] rAddr;
        int sel;
        areset_n    = 1'b0;
        ar_valid    = 1'b0;
        ar_addr     = '0;
        ar_len      = '0;
        ar_size     = '0;
        ar_burst    = '0;
        r_ready     = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("reset state", 64'({ar_ready, r_valid, r_last, r_resp, r_data}), 64'({5'b10000, 32'h0}));
        areset_n = 1'b1;
        @(posedge aclk); #1;

        for (int a = 0; a < 1024; a++) writeMem(a, $urandom);
        writeMem(4, 32'hA);
        writeMem(5, 32'hB);
        writeMem(6, 32'hC);
        writeMem(7, 32'hD);
        writeMem(1022, 32'h1111);
        writeMem(1023, 32'h2222);

        vecs.push_back(mkVec(32'h10, 8'd3, 3'd2, 2'b01, 0, 32'hA, 32'hB, 32'hC, 32'hD, 8'h00));
        vecs.push_back(mkVec(32'h10, 8'd3, 3'd2, 2'b01, 1, 32'hA, 32'hB, 32'hC, 32'hD, 8'h00));
        vecs.push_back(mkVec(32'h14, 8'd2, 3'd2, 2'b00, 0, 32'hB, 32'hB, 32'hB, 32'h0, 8'h00));
`ifdef AXI_RD_WRAP_EN
        vecs.push_back(mkVec(32'h18, 8'd3, 3'd2, 2'b10, 0, 32'hC, 32'hD, 32'hA, 32'hB, 8'h00));
`else
        vecs.push_back(mkVec(32'h18, 8'd3, 3'd2, 2'b10, 0, 32'h0, 32'h0, 32'h0, 32'h0, 8'hAA));
`endif
        vecs.push_back(mkVec(32'hFF8, 8'd3, 3'd2, 2'b01, 1, 32'h1111, 32'h2222, 32'h0, 32'h0, 8'hA0));
        vecs.push_back(mkVec(32'h10, 8'd3, 3'd3, 2'b01, 0, 32'h0, 32'h0, 32'h0, 32'h0, 8'hAA));
        vecs.push_back(mkVec(32'h10, 8'd1, 3'd2, 2'b11, 0, 32'h0, 32'h0, 32'h0, 32'h0, 8'h0A));
        vecs.push_back(mkVec(32'h1C, 8'd0, 3'd2, 2'b01, 0, 32'hD, 32'h0, 32'h0, 32'h0, 8'h00));
        vecs.push_back(mkVec(32'h11, 8'd1, 3'd0, 2'b01, 2, 32'hA, 32'hB, 32'h0, 32'h0, 8'h00));

        for (int i = 0; i < vecs.size(); i++) runVec(i);

        // Reset asserted while beat 1 of a 4-beat burst is presented
        ar_valid = 1'b1;
        ar_addr  = 32'h10;
        ar_len   = 8'd3;
        ar_size  = 3'd2;
        ar_burst = 2'b01;
        @(posedge aclk); #1;
        ar_valid = 1'b0;
        checkOutput("rst beat0", 64'({r_valid, r_data}), 64'({1'b1, 32'hA}));
        r_ready = 1'b1;
        @(posedge aclk); #1;
        r_ready = 1'b0;
        checkOutput("rst beat1", 64'({r_valid, r_data}), 64'({1'b1, 32'hB}));
        #1 areset_n = 1'b0;
        #1;
        checkOutput("rst immediate", 64'({ar_ready, r_valid, r_last, r_resp, r_data}), 64'({5'b10000, 32'h0}));
        @(negedge aclk);
        areset_n = 1'b1;
        r_ready  = 1'b1;
        @(posedge aclk); #1;
        r_ready  = 1'b0;
        checkOutput("rst no beats", 64'({ar_ready, r_valid}), 64'(2'b10));
        runVec(0);

        // Sideband write and first-beat load on the same word at the same edge
        expData[0] = 32'hB;
        expResp[0] = 2'b00;
        expData[1] = 32'h55;
        expResp[1] = 2'b00;
        applyStimulus("collide", 32'h14, 8'd1, 3'd2, 2'b00, 0, 1'b1, 5, 32'h55);
        writeMem(5, 32'hB);

        // Randomized bursts against the behavioural model
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 2) == 0) writeMem($urandom_range(0, 1023), $urandom);
            sel = $urandom_range(0, 9);
            if (sel < 7)      rAddr = $urandom_range(0, 4095);
            else if (sel < 9) rAddr = $urandom_range(4032, 4095);
            else              rAddr = $urandom;
            ar_len   = 8'($urandom_range(0, 15));
            ar_size  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            ar_burst = 2'($urandom_range(0, 3));
            modelBurst(rAddr, ar_len, ar_size, ar_burst);
            applyStimulus($sformatf("rnd%0d", t), rAddr, ar_len, ar_size, ar_burst, 2, 1'b0, 0, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_slave_rd.md
Name: axi_slave_rd

Overview:
AXI read-side slave: accepts read address requests on the AR channel and returns burst data on the R channel from a local word-addressed memory. It is the read counterpart of the write slave and shares the same parameter set and memory organisation. A sideband write port lets the write slave (or a testbench) fill the memory.

Parameters:
ADDR_BITS, 32, AR address width (byte address)
DATA_BITS, 32, R data width; bytes per beat BPB = DATA_BITS/8
LEN_BITS, 8, ar_len width; beats = ar_len+1
SIZE_BITS, 3, ar_size width
MEM_DEPTH, 1024, memory depth in words

Ports:
aclk  in  1  clock
areset_n  in  1  asynchronous active-low reset
ar_ready  out  1  address channel ready
ar_valid  in  1  address channel valid
ar_addr  in  ADDR_BITS  start byte address
ar_len  in  LEN_BITS  beats minus one
ar_size  in  SIZE_BITS  log2 bytes per beat
ar_burst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
r_valid  out  1  read data valid
r_ready  in  1  read data ready
r_data  out  DATA_BITS  read data
r_last  out  1  final beat of burst
r_resp  out  2  00 OKAY, 10 SLVERR
mem_wr_en  in  1  sideband memory write enable
mem_wr_addr  in  $clog2(MEM_DEPTH)  sideband word index
mem_wr_data  in  DATA_BITS  sideband write data

Behaviour:
- Reset: areset_n is asynchronous, active-low; clock is aclk. On reset: ar_ready=1, r_valid=0, r_last=0, r_resp=00, r_data=0, state=IDLE. Memory contents are not reset. Reset mid-burst aborts the burst with no further beats.
- Word index = addr >> log2(BPB). The beat counter and current index are registered.
- FSM IDLE: ar_ready=1. ar_valid&&ar_ready at edge E latches addr/len/size/burst, drops ar_ready, and moves to BURST. Beat 0 is registered so r_valid=1 at edge E+1.
- FSM BURST: ar_ready=0.
  - While r_valid && !r_ready, r_data, r_last and r_resp are held stable.
  - On r_valid && r_ready, the next beat loads at the same edge, giving one beat per cycle under continuous r_ready.
  - r_last=1 only on beat ar_len.
  - When the last beat is accepted: r_valid=0, r_last=0, ar_ready=1, back to IDLE at the same edge. The next AR handshake is possible the following cycle.
- Address update:
  - FIXED: index constant.
  - INCR: index+1 per beat.
  - WRAP: index+1, wrapping within an aligned block of (ar_len+1) words.
- Error rules. Each rule applies per beat; on error r_data=0, r_resp=10, and the burst still runs its full length with correct r_last.
  - ar_size > log2(BPB): SLVERR.
  - Reserved burst 11: SLVERR.
  - Word index >= MEM_DEPTH: SLVERR. An INCR burst crossing the top errors only on out-of-range beats; the index does not wrap to 0.
- Memory: register array, combinational read into the r_data register. mem_wr_en writes at the edge. If a sideband write and a beat load hit the same word at the same edge, r_data gets the old value.

Optional Feature:
AXI_RD_WRAP_EN.
- Defined: WRAP bursts are supported as above. ar_len must be 1, 3, 7 or 15; any other length gives SLVERR on all beats.
- Undefined: ar_burst=10 is treated as reserved, giving SLVERR on all beats, data 0, and full beat count with r_last.

Test Plan:
- Preload word 4=0xA, 5=0xB, 6=0xC, 7=0xD. INCR addr 0x10, len 3, size 2, r_ready=1 -> r_valid one edge after handshake; data A,B,C,D on consecutive cycles; r_last on D; r_resp 00; ar_ready high the cycle after D.
- Same INCR burst with r_ready toggling 1,0,0,1,... -> each beat held stable while stalled; beat order unchanged; exactly 4 beats.
- FIXED addr 0x14, len 2 -> 0xB three times; r_last on third beat.
- WRAP addr 0x18, len 3, words 4..7 loaded -> with AXI_RD_WRAP_EN: C,D,A,B. Without it: 4 beats, data 0, r_resp 10, r_last on fourth beat.
- INCR addr word 1022, len 3, MEM_DEPTH 1024 -> beats 0-1 OKAY with data; beats 2-3 SLVERR, data 0. Separately, ar_size=3 -> all beats SLVERR.
- Assert areset_n low during beat 1 of a 4-beat burst -> r_valid=0 and ar_ready=1 immediately. After release, a new burst returns correct data from beat 0.
